// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID-stage operand reads
// and the writeback register file.
interface wb_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [1:0]    WBreg;
    logic [DW-1:0] Memreg;
    logic [DW-1:0] ALUreg;
    logic [AW-1:0] RegRDreg;
    logic [AW-1:0] RegRS;
    logic [AW-1:0] RegRT;
    logic [DW-1:0] ReadA;
    logic [DW-1:0] ReadB;
    logic [DW-1:0] WBData;
    logic          WBValid;
    logic [31:0]   WBCount;

    modport master (
        output WBreg, Memreg, ALUreg, RegRDreg, RegRS, RegRT,
        input  ReadA, ReadB, WBData, WBValid, WBCount
    );

    modport slave (
        input  WBreg, Memreg, ALUreg, RegRDreg, RegRS, RegRT,
        output ReadA, ReadB, WBData, WBValid, WBCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it into a register
// file with r0 hardwired to zero, and serves two bypassed read ports.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    wb_regfile_if.slave wb
);
    localparam int AW = $clog2(NREG);

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] wb_data;
    logic          wb_valid;
    logic [31:0]   wb_count;
    logic [DW-1:0] read_a;
    logic [DW-1:0] read_b;

    assign wb_data  = wb.WBreg[0] ? wb.Memreg : wb.ALUreg;
    assign wb_valid = reset_n && wb.WBreg[1] && (wb.RegRDreg != '0);

    // Reads are gated by reset so the bypass path also returns zero in reset.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
        if (!reset_n || addr == '0)
            return '0;
        else if (wb_valid && addr == wb.RegRDreg)
            return wb_data;
        else
            return regs[addr];
    endfunction

    always_comb begin
        read_a = read_port(wb.RegRS);
        read_b = read_port(wb.RegRT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_valid) begin
            regs[wb.RegRDreg] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wb_count <= '0;
        else if (wb_valid)
            wb_count <= wb_count + 32'd1;
    end

    assign wb.ReadA   = read_a;
    assign wb.ReadB   = read_b;
    assign wb.WBData  = wb_data;
    assign wb.WBValid = wb_valid;
    assign wb.WBCount = wb_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized checks of the writeback register file, bypass,
// register zero handling, reset and commit counter.
module tb_wb_regfile;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] model [32];
    logic [31:0] model_count;

    wb_regfile_if #(.DW(32), .AW(5)) bus ();

    wb_regfile #(.NREG(32), .DW(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .wb      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wbreg, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        bus.WBreg    = wbreg;
        bus.Memreg   = mem;
        bus.ALUreg   = alu;
        bus.RegRDreg = rd;
        bus.RegRS    = rs;
        bus.RegRT    = rt;
    endtask

    function automatic logic [31:0] exp_wbdata();
        return bus.WBreg[0] ? bus.Memreg : bus.ALUreg;
    endfunction

    function automatic logic exp_valid();
        return reset_n && bus.WBreg[1] && (bus.RegRDreg != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!reset_n || a == 5'd0) return 32'd0;
        if (exp_valid() && a == bus.RegRDreg) return exp_wbdata();
        return model[a];
    endfunction

    // Advance one cycle, mirroring the commit in the model, and return to a negedge.
    task automatic step();
        @(posedge clock);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model_count = 32'd0;
        end else if (exp_valid()) begin
            model[bus.RegRDreg] = exp_wbdata();
            model_count = model_count + 32'd1;
        end
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_count = 32'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset_n = 1'b0;
        drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd4);
        repeat (2) @(negedge clock);
        #1;
        check("reset_read_a", bus.ReadA, 32'd0);
        check("reset_count", bus.WBCount, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // ALU writeback
        drive(2'b10, 32'h0, 32'h1234_5678, 5'd5, 5'd0, 5'd0);
        #1;
        check("alu_valid", {31'd0, bus.WBValid}, 32'd1);
        check("alu_wbdata", bus.WBData, 32'h1234_5678);
        step();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        #1;
        check("alu_read", bus.ReadA, 32'h1234_5678);
        check("alu_count", bus.WBCount, 32'd1);

        // load writeback
        drive(2'b11, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd0, 5'd0);
        step();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        #1;
        check("mem_read", bus.ReadA, 32'hDEAD_BEEF);
        check("mem_count", bus.WBCount, 32'd2);

        // bypass on both ports
        drive(2'b10, 32'h0, 32'h1, 5'd7, 5'd0, 5'd0);
        step();
        drive(2'b10, 32'h0, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7);
        #1;
        check("bypass_a", bus.ReadA, 32'hA5A5_A5A5);
        check("bypass_b", bus.ReadB, 32'hA5A5_A5A5);
        step();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        #1;
        check("array_a", bus.ReadA, 32'hA5A5_A5A5);
        check("array_b", bus.ReadB, 32'hA5A5_A5A5);
        check("bypass_count", bus.WBCount, 32'd4);

        // write to register zero
        drive(2'b11, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("r0_valid", {31'd0, bus.WBValid}, 32'd0);
        check("r0_read", bus.ReadA, 32'd0);
        check("r0_wbdata", bus.WBData, 32'hFFFF_FFFF);
        step();
        #1;
        check("r0_read_next", bus.ReadA, 32'd0);
        check("r0_count", bus.WBCount, 32'd4);

        // bubble with MemtoReg only
        drive(2'b10, 32'h0, 32'h77, 5'd9, 5'd0, 5'd0);
        step();
        drive(2'b01, 32'h55, 32'h0, 5'd9, 5'd9, 5'd0);
        #1;
        check("bubble_read", bus.ReadA, 32'h77);
        check("bubble_valid", {31'd0, bus.WBValid}, 32'd0);
        check("bubble_wbdata", bus.WBData, 32'h55);
        step();
        #1;
        check("bubble_read_next", bus.ReadA, 32'h77);
        check("bubble_count", bus.WBCount, 32'd5);

        // asynchronous reset mid-cycle, held across a would-be commit
        drive(2'b10, 32'h0, 32'h0000_CAFE, 5'd5, 5'd5, 5'd9);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_read_a", bus.ReadA, 32'd0);
        check("rst_read_b", bus.ReadB, 32'd0);
        check("rst_count", bus.WBCount, 32'd0);
        check("rst_valid", {31'd0, bus.WBValid}, 32'd0);
        check("rst_wbdata", bus.WBData, 32'h0000_CAFE);
        step();
        reset_n = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9);
        #1;
        check("post_rst_a", bus.ReadA, 32'd0);
        check("post_rst_b", bus.ReadB, 32'd0);
        check("post_rst_count", bus.WBCount, 32'd0);

        // first edge after release commits
        drive(2'b10, 32'h0, 32'h0000_0042, 5'd3, 5'd0, 5'd0);
        step();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        #1;
        check("first_commit", bus.ReadA, 32'h42);
        check("first_count", bus.WBCount, 32'd1);

        // counter wrap via preload
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        model_count = 32'hFFFF_FFFF;
        drive(2'b10, 32'h0, 32'h3, 5'd3, 5'd0, 5'd0);
        step();
        #1;
        check("count_wrap", bus.WBCount, 32'd0);

        for (int n = 0; n < 1000; n++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, rd,
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)));
            #1;
            check("rnd_read_a", bus.ReadA, exp_read(bus.RegRS));
            check("rnd_read_b", bus.ReadB, exp_read(bus.RegRT));
            check("rnd_wbdata", bus.WBData, exp_wbdata());
            check("rnd_valid", {31'd0, bus.WBValid}, {31'd0, exp_valid()});
            step();
            #1;
            check("rnd_count", bus.WBCount, model_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
